gmii_rx: RTL

- GMII receive stage that sits directly downstream of the PHY on the receiving board and consumes the UDP video frames produced by the transmit stage.
- Strips preamble/SFD, filters on MAC, EtherType, IP protocol and UDP port, and decodes the packet-ident byte.
- Emits the 2-byte line header and 1280 pixel bytes, as 16-bit pairs, into the video FIFO.
- Checks the Ethernet FCS and reports per-packet good/bad so the downstream FIFO can commit or discard the line.

---
 rtl/gmii_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/gmii_rx.sv
// GMII receive stage: strips preamble/SFD, filters on MAC/EtherType/IP/UDP port,
// extracts the line header and pixel pairs for the video FIFO, and checks the FCS.
module gmii_rx #(
  parameter logic [47:0] LOCAL_MAC = 48'h002345678902,
  parameter logic [15:0] UDP_PORT  = 16'h3039,
  parameter logic [10:0] PIX_BYTES = 11'd1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst_n,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        vid_full,
  output logic        vid_wr_en,
  output logic [15:0] vid_din,
  output logic        line_wr_en,
  output logic [15:0] line_hdr,
  output logic [7:0]  pkt_type,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, IDNT, RESOL, PIXEL, TAIL, DROP} state_t;

  state_t      state;
  state_t      nxt;
  logic        armed;
  logic [2:0]  pre_cnt;
  logic [5:0]  bcnt;
  logic [10:0] pcnt;
  logic        rcnt;
  logic [7:0]  hold;
  logic [31:0] crc;
  logic        err;
  logic        ovf;
  logic [47:0] mac_exp;
  logic        hdr_chk;
  logic [7:0]  hdr_exp;
  logic        hdr_bad;
  logic        eof;
  logic        ok_now;
  logic [31:0] crc_next;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  assign mac_exp  = {LOCAL_MAC[47:8], LOCAL_MAC[7:0] - {7'd0, id}};
  assign crc_next = crc32_byte(crc, rxd);
  assign hdr_bad  = hdr_chk && (rxd != hdr_exp);
  assign eof      = !rx_dv && (state == IDNT || state == RESOL || state == PIXEL || state == TAIL);
  // Residue of the reflected register read MSB-first; only TAIL means the pixel count completed
  assign ok_now   = (bitrev32(crc) == 32'hC704DD7B) && !err && !ovf && (state == TAIL);

  // Header field selection by byte offset after the SFD
  always_comb begin
    hdr_chk = 1'b1;
    hdr_exp = 8'h00;
    case (bcnt)
      6'd0:    hdr_exp = mac_exp[47:40];
      6'd1:    hdr_exp = mac_exp[39:32];
      6'd2:    hdr_exp = mac_exp[31:24];
      6'd3:    hdr_exp = mac_exp[23:16];
      6'd4:    hdr_exp = mac_exp[15:8];
      6'd5:    hdr_exp = mac_exp[7:0];
      6'd12:   hdr_exp = 8'h08;
      6'd13:   hdr_exp = 8'h00;
      6'd14:   hdr_exp = 8'h45;
      6'd23:   hdr_exp = 8'h11;
      6'd36:   hdr_exp = UDP_PORT[15:8];
      6'd37:   hdr_exp = UDP_PORT[7:0];
      default: hdr_chk = 1'b0;
    endcase
  end

  // Next-state logic; accepted frames finish through DROP so a back-to-back start is ignored
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (armed && rx_dv) nxt = (rxd == 8'h55) ? PRE : DROP;
        else nxt = IDLE;
      end
      PRE: begin
        if (!rx_dv) nxt = DROP;
        else if (rxd == 8'h55) nxt = (pre_cnt == 3'd7) ? DROP : PRE;
        else if (rxd == 8'hD5) nxt = HDR;
        else nxt = DROP;
      end
      HDR: begin
        if (!rx_dv || hdr_bad) nxt = DROP;
        else if (bcnt == 6'd41) nxt = IDNT;
        else nxt = HDR;
      end
      IDNT: begin
        if (!rx_dv) nxt = DROP;
        else if (rxd == 8'h00 || rxd == 8'h02) nxt = RESOL;
        else nxt = TAIL;
      end
      RESOL: begin
        if (!rx_dv) nxt = DROP;
        else if (rcnt) nxt = PIXEL;
        else nxt = RESOL;
      end
      PIXEL: begin
        if (!rx_dv) nxt = DROP;
        else if (pcnt == PIX_BYTES - 11'd1) nxt = TAIL;
        else nxt = PIXEL;
      end
      TAIL: begin
        if (!rx_dv) nxt = DROP;
        else nxt = TAIL;
      end
      DROP: begin
        if (!rx_dv) nxt = IDLE;
        else nxt = DROP;
      end
      default: nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else state <= nxt;
  end

  // Arm only after an idle cycle so a reset released mid-frame cannot lock on
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) armed <= 1'b0;
    else if (!rx_dv) armed <= 1'b1;
    else armed <= armed;
  end

  // Frame bookkeeping: preamble count, byte counters, CRC and sticky error flags
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt <= 3'd0;
      bcnt    <= 6'd0;
      pcnt    <= 11'd0;
      rcnt    <= 1'b0;
      hold    <= 8'h00;
      crc     <= 32'hFFFFFFFF;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: pre_cnt <= 3'd1;
        PRE: begin
          pre_cnt <= pre_cnt + 3'd1;
          bcnt    <= 6'd0;
          pcnt    <= 11'd0;
          rcnt    <= 1'b0;
          crc     <= 32'hFFFFFFFF;
          err     <= 1'b0;
          ovf     <= 1'b0;
        end
        HDR, IDNT, RESOL, PIXEL, TAIL: begin
          if (rx_dv) begin
            crc <= crc_next;
            if (rx_er) err <= 1'b1;
            if (state == HDR) bcnt <= bcnt + 6'd1;
            if (state == RESOL) begin
              rcnt <= ~rcnt;
              if (!rcnt) hold <= rxd;
            end
            if (state == PIXEL) begin
              pcnt <= pcnt + 11'd1;
              if (!pcnt[0]) hold <= rxd;
              else if (vid_full) ovf <= 1'b1;
            end
          end
        end
        default: pre_cnt <= pre_cnt;
      endcase
    end
  end

  // Registered outputs: strobes, decoded fields, status and saturating counters
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vid_wr_en   <= 1'b0;
      vid_din     <= 16'h0000;
      line_wr_en  <= 1'b0;
      line_hdr    <= 16'h0000;
      pkt_type    <= 8'h00;
      pkt_done    <= 1'b0;
      pkt_ok      <= 1'b0;
      crc_err_cnt <= 16'h0000;
      drop_cnt    <= 16'h0000;
    end else begin
      vid_wr_en  <= 1'b0;
      line_wr_en <= 1'b0;
      pkt_done   <= 1'b0;
      if (state == IDNT && rx_dv) pkt_type <= rxd;
      if (state == RESOL && rx_dv && rcnt) begin
        line_hdr   <= {hold, rxd};
        line_wr_en <= 1'b1;
      end
      if (state == PIXEL && rx_dv && pcnt[0] && !vid_full) begin
        vid_din   <= {hold, rxd};
        vid_wr_en <= 1'b1;
      end
      if (state == HDR && rx_dv && hdr_bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (eof) begin
        pkt_done <= 1'b1;
        pkt_ok   <= ok_now;
        if (!ok_now && crc_err_cnt != 16'hFFFF) crc_err_cnt <= crc_err_cnt + 16'd1;
      end
    end
  end

endmodule
